// File: rtl/alu_muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_seq_if
// Description : Bundle of the multiply/divide sequencer request/response
//               handshake and the borrowed-ALU operand/result bus.
//               master : requester / execute stage side (drives start, op,
//                        opa, opb and returns the shared ALU result alu_r)
//               slave  : the sequencer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_muldiv_seq_if;
    logic        start;     // request, accepted when start && ready
    logic [1:0]  op;        // op[0]: 0 mul / 1 div, op[1]: signed request
    logic [31:0] opa;       // multiplicand / dividend
    logic [31:0] opb;       // multiplier / divisor
    logic        ready;     // idle, may accept
    logic        busy;      // operation in flight
    logic        done;      // one-cycle pulse, hi/lo valid
    logic [31:0] hi;        // product[63:32] / remainder
    logic [31:0] lo;        // product[31:0]  / quotient
    logic        alu_sel;   // shared ALU operand mux selects the sequencer
    logic [31:0] alu_a;     // ALU operand a
    logic [31:0] alu_b;     // ALU operand b
    logic [3:0]  alu_aluc;  // ALU op code
    logic [31:0] alu_r;     // ALU result

    modport master (
        output start, op, opa, opb, alu_r,
        input  ready, busy, done, hi, lo, alu_sel, alu_a, alu_b, alu_aluc
    );

    modport slave (
        input  start, op, opa, opb, alu_r,
        output ready, busy, done, hi, lo, alu_sel, alu_a, alu_b, alu_aluc
    );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_seq
// Description : Multi-cycle MULT(U)/DIV(U) sequencer. Borrows the shared
//               32-bit ALU for 32 iterations of shift-add (multiply) or
//               restoring shift-subtract (divide) and returns {hi, lo} with
//               a one-cycle done pulse.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - alu_muldiv_seq_if.slave: start/op/opa/opb request,
//                      ready/busy/done/hi/lo response, alu_sel/alu_a/alu_b/
//                      alu_aluc drive and alu_r return of the shared ALU
// Config      : MULDIV_SIGNED_EN - when defined, op[1]=1 selects a signed
//               operation (magnitudes at accept, sign fix-up in FIX state).
//               When undefined, every operation is unsigned.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq (
    input  logic             clk,
    input  logic             rst,
    alu_muldiv_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,   // reachable only in the signed build
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] C_ALUC_ADD = 4'b0000;
    localparam logic [3:0] C_ALUC_SUB = 4'b0001;

    state_t      state_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] m_q;         // multiplicand M or divisor D (magnitude)
    logic [4:0]  cnt_q;
    logic        div_q;
    logic        neg_lo_q;    // negate product (mul) / quotient (div)
    logic        neg_hi_q;    // negate remainder (div only)
    logic        ready_q, busy_q, done_q;

    // ---------------------------------------------------------------- signed
    logic        signed_op_w;
`ifdef MULDIV_SIGNED_EN
    assign signed_op_w = bus.op[1];
`else
    assign signed_op_w = 1'b0;
    logic  unused_op1_w;
    assign unused_op1_w = bus.op[1];
`endif

    logic        a_neg_w, b_neg_w;
    logic [31:0] a_mag_w, b_mag_w;
    assign a_neg_w = signed_op_w & bus.opa[31];
    assign b_neg_w = signed_op_w & bus.opb[31];
    assign a_mag_w = a_neg_w ? (~bus.opa + 32'd1) : bus.opa;
    assign b_mag_w = b_neg_w ? (~bus.opb + 32'd1) : bus.opb;

    // -------------------------------------------------------------- datapath
    // Divide: partial remainder shifted left by one, with the bit that falls
    // off the top kept aside; if it is set the shifted value exceeds 32 bits
    // and the subtraction must always be taken.
    logic [31:0] rs_w;
    logic        take_w;
    logic        carry_w;
    logic [63:0] prod_neg_w;
    assign rs_w       = {hi_q[30:0], lo_q[31]};
    assign take_w     = hi_q[31] | (rs_w >= m_q);
    // Carry out of hi + addend, recovered from wrap-around of the ALU sum.
    assign carry_w    = (bus.alu_r < hi_q);
    assign prod_neg_w = ~{hi_q, lo_q} + 64'd1;

    logic        alu_sel_w;
    logic [31:0] alu_a_w, alu_b_w;
    logic [3:0]  alu_aluc_w;
    always_comb begin
        alu_sel_w  = 1'b0;
        alu_a_w    = 32'd0;
        alu_b_w    = 32'd0;
        alu_aluc_w = C_ALUC_ADD;
        if (state_q == S_RUN) begin
            alu_sel_w = 1'b1;
            if (div_q) begin
                alu_a_w    = rs_w;
                alu_b_w    = m_q;
                alu_aluc_w = C_ALUC_SUB;
            end else begin
                alu_a_w    = hi_q;
                alu_b_w    = lo_q[0] ? m_q : 32'd0;
            end
        end
    end

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            m_q      <= 32'd0;
            cnt_q    <= 5'd0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        div_q    <= bus.op[0];
                        hi_q     <= 32'd0;
                        cnt_q    <= 5'd0;
                        neg_lo_q <= a_neg_w ^ b_neg_w;
                        if (bus.op[0]) begin
                            lo_q     <= a_mag_w;
                            m_q      <= b_mag_w;
                            neg_hi_q <= a_neg_w;
                        end else begin
                            lo_q     <= b_mag_w;
                            m_q      <= a_mag_w;
                            neg_hi_q <= 1'b0;
                        end
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (div_q) begin
                        hi_q <= take_w ? bus.alu_r : rs_w;
                        lo_q <= {lo_q[30:0], take_w};
                    end else begin
                        hi_q <= {carry_w, bus.alu_r[31:1]};
                        lo_q <= {bus.alu_r[0], lo_q[31:1]};
                    end
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        if (neg_lo_q | neg_hi_q) begin
                            state_q <= S_FIX;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_FIX: begin
                    if (div_q) begin
                        if (neg_lo_q) lo_q <= ~lo_q + 32'd1;
                        if (neg_hi_q) hi_q <= ~hi_q + 32'd1;
                    end else if (neg_lo_q) begin
                        {hi_q, lo_q} <= prod_neg_w;
                    end
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.alu_sel  = alu_sel_w;
    assign bus.alu_a    = alu_a_w;
    assign bus.alu_b    = alu_b_w;
    assign bus.alu_aluc = alu_aluc_w;
endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv_seq
// Description : Self-checking bench for alu_muldiv_seq. A behavioural model
//               (plain 64-bit arithmetic, cycle-offset bookkeeping) is
//               compared against the DUT on every falling edge; directed
//               literal cases pin the model; a randomized phase drives
//               start/op/operands/rst freely. The shared ALU is emulated.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_muldiv_seq_if bus ();

    alu_muldiv_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Shared ALU: add for aluc 0000, subtract for 0001.
    assign bus.alu_r = (bus.alu_aluc == 4'b0001) ? (bus.alu_a - bus.alu_b)
                                                 : (bus.alu_a + bus.alu_b);

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ ref model
    function automatic void model(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [63:0] res,
                                  output int lat);
        logic        sgn, an, bn;
        logic [31:0] am, bm, q, r;
        logic [63:0] p;
        sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
        sgn = op[1];
`endif
        an  = sgn && a[31];
        bn  = sgn && b[31];
        am  = an ? (~a + 32'd1) : a;
        bm  = bn ? (~b + 32'd1) : b;
        lat = 33;
        if (!op[0]) begin
            p = {32'd0, am} * {32'd0, bm};
            if (an ^ bn) begin
                p   = ~p + 64'd1;
                lat = 34;
            end
            res = p;
        end else begin
            if (bm == 32'd0) begin
                q = 32'hFFFFFFFF;
                r = am;
            end else begin
                q = am / bm;
                r = am % bm;
            end
            if (an ^ bn) q = ~q + 32'd1;
            if (an)      r = ~r + 32'd1;
            if ((an ^ bn) || an) lat = 34;
            res = {r, q};
        end
    endfunction

    // m_k: cycle offset from the accept edge (0 = idle)
    bit          m_valid = 1'b0;
    int          m_k     = 0;
    int          m_lat   = 33;
    bit          m_div   = 1'b0;
    logic [63:0] m_res   = 64'd0;
    logic [31:0] m_hi    = 32'd0;
    logic [31:0] m_lo    = 32'd0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("ready",   {63'd0, bus.ready},   {63'd0, m_k == 0});
            chk("busy",    {63'd0, bus.busy},    {63'd0, m_k != 0});
            chk("done",    {63'd0, bus.done},    {63'd0, m_k != 0 && m_k == m_lat});
            chk("alu_sel", {63'd0, bus.alu_sel}, {63'd0, m_k >= 1 && m_k <= 32});
            if (m_k >= 1 && m_k <= 32) begin
                chk("alu_aluc_run", {60'd0, bus.alu_aluc}, m_div ? 64'd1 : 64'd0);
            end else begin
                chk("alu_aluc_idle", {60'd0, bus.alu_aluc}, 64'd0);
                chk("alu_a_idle",    {32'd0, bus.alu_a},    64'd0);
                chk("alu_b_idle",    {32'd0, bus.alu_b},    64'd0);
            end
            if (m_k == 0)
                chk("hilo_hold", {bus.hi, bus.lo}, {m_hi, m_lo});
            else if (m_k == m_lat)
                chk("result", {bus.hi, bus.lo}, m_res);
        end
        if (rst) begin
            m_valid = 1'b1;
            m_k     = 0;
            m_hi    = 32'd0;
            m_lo    = 32'd0;
        end else if (m_valid) begin
            if (m_k == 0) begin
                if (bus.start) begin
                    model(bus.op, bus.opa, bus.opb, m_res, m_lat);
                    m_div = bus.op[0];
                    m_k   = 1;
                end
            end else if (m_k == m_lat) begin
                m_k = 0;
                {m_hi, m_lo} = m_res;
            end else begin
                m_k++;
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic wait_ready();
        int n = 0;
        while (!bus.ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", {63'd0, bus.ready}, 64'd1);
    endtask

    // Issue one op and compare result and latency with literal expectations.
    task automatic lit_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int elat, input bit inject);
        int n;
        wait_ready();
        bus.op = op; bus.opa = a; bus.opb = b; bus.start = 1'b1;
        @(posedge clk); #1;           // accept edge T, now in cycle T+1
        n = 1;
        while (!bus.done && n < 60) begin
            if (inject && n == 5) begin
                bus.start = 1'b1; bus.op = 2'b00; bus.opa = 32'h0000DEAD; bus.opb = 32'h3;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        bus.start = 1'b0;
        chk({name, "_lat"}, n, elat);
        chk({name, "_hi"},  {32'd0, bus.hi}, {32'd0, ehi});
        chk({name, "_lo"},  {32'd0, bus.lo}, {32'd0, elo});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.op = 2'b00; bus.opa = 32'd0; bus.opb = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_ready", {63'd0, bus.ready}, 64'd1);
        chk("reset_hilo",  {bus.hi, bus.lo},   64'd0);

        lit_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1'b0);
        lit_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0);
        lit_op("divu_by0", 2'b01, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 33, 1'b0);
        lit_op("busy_start", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b1);
`ifdef MULDIV_SIGNED_EN
        lit_op("div_m7_2",  2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 1'b0);
        lit_op("mult_m3_5", 2'b10, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 34, 1'b0);
`else
        lit_op("div_m7_2",  2'b11, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 33, 1'b0);
        lit_op("mult_m3_5", 2'b10, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1, 33, 1'b0);
`endif

        // Reset in the middle of a multiply.
        begin
            bit saw_done = 1'b0;
            wait_ready();
            bus.op = 2'b00; bus.opa = 32'hFFFFFFFF; bus.opb = 32'hFFFFFFFF; bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            repeat (9) begin @(posedge clk); #1; end   // now in cycle T+10
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            chk("rst_mid_ready", {63'd0, bus.ready}, 64'd1);
            chk("rst_mid_busy",  {63'd0, bus.busy},  64'd0);
            chk("rst_mid_hilo",  {bus.hi, bus.lo},   64'd0);
            repeat (40) begin
                if (bus.done) saw_done = 1'b1;
                @(posedge clk); #1;
            end
            chk("rst_mid_no_done", {63'd0, saw_done}, 64'd0);
            lit_op("after_rst", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0);
        end

        // Randomized phase: free-running start/op/operands with rare resets.
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 599) == 0);
            bus.start = ($urandom_range(0, 2) != 0);
            bus.op    = 2'($urandom_range(0, 3));
            bus.opa   = pick();
            bus.opb   = pick();
            @(posedge clk); #1;
        end
        rst = 1'b0; bus.start = 1'b0;
        repeat (40) begin @(posedge clk); #1; end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Multi-cycle multiply/divide sequencer that borrows the shared 32-bit ALU to execute MULT(U)/DIV(U) by iterated shift-add and restoring shift-subtract. It sits beside the execute stage, takes an operation over a start/ready handshake, owns the ALU operand mux while running, and returns a 64-bit {hi, lo} result with a one-cycle done pulse. ALU flags are not used; carry and borrow are derived locally from ALU operands and result.

## Interface
- No parameters; datapath width fixed at 32.
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted when start && ready
- op  in  2  op[0]: 0 = multiply, 1 = divide; op[1]: 1 = signed (see Configuration)
- opa  in  32  multiplicand / dividend
- opb  in  32  multiplier / divisor
- ready  out  1  idle, may accept
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse, hi/lo valid
- hi  out  32  product[63:32] / remainder
- lo  out  32  product[31:0] / quotient
- alu_sel  out  1  datapath ALU mux selects this block
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_aluc  out  4  ALU op code
- alu_r  in  32  ALU result (outmux9)

## Operation
- States: IDLE, RUN, FIX (signed build only), DONE.
- IDLE: ready=1. On start: latch opa/opb (magnitudes if signed), latch op, clear count; go RUN.
- RUN: alu_sel=1, 32 iterations, count 0..31, one ALU op per cycle; after iteration 31 go FIX if signed correction pending, else DONE.
- Multiply (aluc=4'b0000 add): alu_a=hi, alu_b = lo[0] ? M : 0; c = (alu_r < hi) unsigned; {hi,lo} <= {c, alu_r, lo[31:1]}. hi cleared and lo=multiplier at accept.
- Divide (aluc=4'b0001 sub): Rs={hi[30:0], lo[31]}, top=hi[31]; alu_a=Rs, alu_b=D; take = top | (Rs >= D); hi <= take ? alu_r : Rs; lo <= {lo[30:0], take}. hi cleared and lo=dividend at accept.
- Divide by zero falls out of the algorithm: lo=32'hFFFFFFFF, hi=dividend; no exception.
- DONE: done=1 for one cycle; return IDLE. hi/lo hold until next accept.
- Outside RUN: alu_sel=0, alu_a=0, alu_b=0, alu_aluc=4'b0000.
- start while not ready: ignored, not queued.

## Timing
- Reset values: ready=1, busy=0, done=0, hi=0, lo=0, alu_sel=0, alu_a=0, alu_b=0, alu_aluc=0; state IDLE, count 0.
- Accept edge T: busy=1, ready=0 from T+1; RUN cycles T+1..T+32; done=1 at T+33 (T+34 with FIX); ready=1 the cycle after done.
- busy high from first RUN cycle through done cycle inclusive.
- ALU path combinational within a cycle: alu_a/b/aluc driven from current state, alu_r sampled same edge.
- rst during any state: next cycle all outputs at reset values, in-flight op discarded, no done.
- Back-to-back: start held high re-accepts on the first ready cycle after done.

## Configuration
- MULDIV_SIGNED_EN defined: op[1]=1 selects signed. At accept, negative operands converted to magnitude locally; FIX state (one cycle, alu_sel=0) negates 64-bit product if signs differ, negates quotient if signs differ, negates remainder if dividend negative. Unsigned ops skip FIX.
- Not defined: op[1] ignored, all ops unsigned, no FIX state, latency always 33.

## Test plan
- multu 32'hFFFFFFFF x 32'hFFFFFFFF accepted at T -> done at T+33, hi=32'hFFFFFFFE, lo=32'h00000001; alu_sel high exactly T+1..T+32.
- divu 100 / 7 -> lo=14, hi=2; divu 32'h12345678 / 0 -> lo=32'hFFFFFFFF, hi=32'h12345678.
- start pulsed at T+5 during busy with different operands -> ignored, first result unchanged, single done.
- rst asserted at T+10 of a multiply -> next cycle ready=1, busy=0, hi=lo=0, no done pulse; new op then completes normally.
- With MULDIV_SIGNED_EN: div -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF, done at T+34; mult -3 x 5 -> {hi,lo}=64'hFFFFFFFF_FFFFFFF1. Without macro, same div -> unsigned result lo=32'h7FFFFFFC, hi=1, done at T+33.
